// File: rtl/data_memory_hs_pkg.sv
// Shared types for the handshaked data memory: access grain and controller state.
package my_lib;

    typedef enum logic [1:0] {
        GRAIN_WORD = 2'b00,
        GRAIN_BYTE = 2'b01,
        GRAIN_HALF = 2'b10
    } mem_grain_t;

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_WAIT,
        S_RESP
    } dmem_state_t;

endpackage

// File: rtl/data_memory_hs_lane_align.sv
// Byte/half lane extraction for loads and lane merge for stores; purely combinational.
module dmem_lane_align
    import my_lib::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  addr_i,
    input  mem_grain_t  grain_i,
    input  logic        sign_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [3:0]  mask;
    logic [31:0] wrep;

    assign byte_sel = 8'(word_i >> {addr_i, 3'b000});
    assign half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];

    always_comb begin
        load_o = 32'h0;
        mask   = 4'b0000;
        wrep   = wdata_i;
        case (grain_i)
            GRAIN_WORD: begin
                load_o = word_i;
                mask   = 4'b1111;
            end
            GRAIN_BYTE: begin
                load_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
                mask   = 4'b0001 << addr_i;
                wrep   = {4{wdata_i[7:0]}};
            end
            GRAIN_HALF: begin
                load_o = {{16{sign_i & half_sel[15]}}, half_sel};
                mask   = addr_i[1] ? 4'b1100 : 4'b0011;
                wrep   = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Replicated write data lets every lane pick from the same bit positions.
    always_comb begin
        store_o = word_i;
        for (int i = 0; i < 4; i++)
            if (mask[i]) store_o[i*8 +: 8] = wrep[i*8 +: 8];
    end

endmodule

// File: rtl/data_memory_hs.sv
// Handshaked data memory: one outstanding access, configurable response latency,
// address-error flag, and a one-word-per-cycle clear sweep after reset.
module data_memory_hs
    import my_lib::*;
#(
    parameter  int WORDS   = 2048,
    parameter  int LATENCY = 1,
    localparam int IDX_W   = $clog2(WORDS)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_grain,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        busy_clear
);
    logic [31:0]      mem_q [WORDS];
    dmem_state_t      state_q;
    logic [IDX_W-1:0] clr_idx_q;
    logic [3:0]       cnt_q;
    logic [31:0]      rdata_q;
    logic             err_q;

    mem_grain_t       grain;
    logic [IDX_W-1:0] idx;
    logic             addr_err;
    logic             accept;
    logic             st_we;
    logic [31:0]      old_word;
    logic [31:0]      load_val;
    logic [31:0]      store_word;

    assign grain    = mem_grain_t'(req_grain);
    assign idx      = req_addr[IDX_W+1:2];
    assign addr_err = (grain == GRAIN_WORD && req_addr[1:0] != 2'b00)
                   || (grain == GRAIN_HALF && req_addr[0])
                   || (req_grain == 2'b11)
                   || (req_addr[31:2] >= 30'(WORDS));
    assign accept   = !reset && state_q == S_IDLE && req_valid;
    assign st_we    = accept && req_write && !addr_err;
    assign old_word = mem_q[idx];

    dmem_lane_align u_align (
        .word_i  (old_word),
        .wdata_i (req_wdata),
        .addr_i  (req_addr[1:0]),
        .grain_i (grain),
        .sign_i  (req_sign),
        .load_o  (load_val),
        .store_o (store_word)
    );

    // Outputs decode the registered state; reset masks them before its first edge lands.
    assign req_ready  = !reset && state_q == S_IDLE;
    assign rsp_valid  = !reset && state_q == S_RESP;
    assign rsp_rdata  = reset ? 32'h0 : rdata_q;
    assign rsp_error  = !reset && err_q;
    assign busy_clear = reset || state_q == S_CLEAR;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_CLEAR;
            clr_idx_q <= '0;
            cnt_q     <= 4'd0;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    clr_idx_q <= clr_idx_q + 1'b1;
                    if (clr_idx_q == IDX_W'(WORDS - 1)) state_q <= S_IDLE;
                end
                S_IDLE: if (req_valid) begin
                    err_q   <= addr_err;
                    rdata_q <= (addr_err || req_write) ? 32'h0 : load_val;
                    cnt_q   <= 4'(LATENCY - 1);
                    state_q <= (LATENCY == 1) ? S_RESP : S_WAIT;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_q <= S_RESP;
                end
                S_RESP: if (rsp_ready) state_q <= S_IDLE;
                default: state_q <= S_CLEAR;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && state_q == S_CLEAR) mem_q[clr_idx_q] <= 32'h0;
        else if (st_we)                   mem_q[idx]       <= store_word;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (st_we)
            $display("@%h: *%h <= %h", req_pc, {req_addr[31:2], 2'b00}, store_word);
        if (accept && addr_err)
            $display("@%h: *%h SignalException AddressError", req_pc, req_addr);
    end
`endif

endmodule
